text_layer_gen: RTL and testbench

- Producer side of the color mapper's text interface: drives font_addr, text_offset and draw_text for every pixel from a character buffer the NIOS writes.
- Holds a COLS x ROWS character RAM of 7-bit codes and maps DrawX/DrawY to character cell, glyph row and glyph column.
- Outputs feed the color mapper's font_rom lookup directly; the color mapper paints white wherever the selected glyph bit is set.
- Sits between the VGA controller (DrawX/DrawY source) and the color mapper.

---
 rtl/text_layer_gen.sv | 153 +++++++++++++++
 tb/tb_text_layer_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/text_layer_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : text_layer_gen
// Description: Character-buffer text layer; maps DrawX/DrawY to font_rom
//              address, glyph bit index and a draw enable for the color mapper.
// Revision   : 1.0 - initial release
// ============================================================================
module text_layer_gen #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int X0   = 0,
    parameter int Y0   = 0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [6:0]  wr_char,
    input  logic        clear,
    output logic        busy,
    output logic [10:0] font_addr,
    output logic [3:0]  text_offset,
    output logic        draw_text
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);
    localparam logic [12:0] CELL_LIM  = 13'(CELLS);
    localparam logic [10:0] X_LO      = 11'(X0);
    localparam logic [10:0] X_HI      = 11'(X0 + 8 * COLS);
    localparam logic [10:0] Y_LO      = 11'(Y0);
    localparam logic [10:0] Y_HI      = 11'(Y0 + 16 * ROWS);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    logic [1:0]  state;
    logic [11:0] clr_ptr;

    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [6:0]  mem_wdata;

    logic        in_win;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [11:0] rd_idx;

    logic [6:0]  mem [0:CELLS-1];
    logic [6:0]  ram_q;
    logic        win_d;
    logic [2:0]  dx_d;
    logic [3:0]  dy_d;

    // Reset lands in START so the power-up sweep begins on the first edge
    // after release, with busy still low during reset itself.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_START;
            clr_ptr <= 12'd0;
        end else begin
            case (state)
                ST_START: begin
                    state   <= ST_CLEAR;
                    clr_ptr <= 12'd0;
                end
                ST_CLEAR: begin
                    if (clr_ptr == LAST_CELL) begin
                        state   <= ST_IDLE;
                        clr_ptr <= 12'd0;
                    end else begin
                        clr_ptr <= clr_ptr + 12'd1;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= 12'd0;
                    end
                end
                default: begin
                    state   <= ST_START;
                    clr_ptr <= 12'd0;
                end
            endcase
        end
    end

    assign busy = (state == ST_CLEAR);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = 7'd0;
        if (state == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (state == ST_IDLE && wr_en && ({1'b0, wr_addr} < CELL_LIM)) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_char;
        end
    end

    always_comb begin
        in_win = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                 ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
        dx     = DrawX - 10'(X0);
        dy     = DrawY - 10'(Y0);
        rd_idx = 12'(dy[9:4]) * 12'(COLS) + 12'(dx[9:3]);
    end

    // Read and write share one block so a same-cell collision reads old data.
    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        if (in_win)
            ram_q <= mem[rd_idx];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            win_d <= 1'b0;
            dx_d  <= 3'd0;
            dy_d  <= 4'd0;
        end else begin
            win_d <= in_win;
            dx_d  <= dx[2:0];
            dy_d  <= dy[3:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            font_addr   <= 11'd0;
            text_offset <= 4'd0;
            draw_text   <= 1'b0;
        end else if (win_d) begin
            font_addr   <= {ram_q, dy_d};
            text_offset <= {1'b0, 3'd7 - dx_d};
            draw_text   <= (ram_q != 7'd0);
        end else begin
            font_addr   <= 11'd0;
            text_offset <= 4'd0;
            draw_text   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_layer_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_text_layer_gen
// Description: Directed, table-driven bench for text_layer_gen.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_text_layer_gen;

    localparam int NCELL = 2400;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_char;
    logic        clear;
    logic        busy;
    logic [10:0] font_addr;
    logic [3:0]  text_offset;
    logic        draw_text;

    text_layer_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .clear(clear),
        .busy(busy), .font_addr(font_addr), .text_offset(text_offset),
        .draw_text(draw_text)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] exp;
    } vec_t;

    vec_t       vecs[10];
    logic [6:0] model[NCELL];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] pix_now();
        return {font_addr, text_offset, draw_text};
    endfunction

    function automatic logic [15:0] pix_exp(input logic [6:0] ch, input logic [3:0] gy,
                                            input logic [2:0] gx);
        return {ch, gy, 1'b0, 3'd7 - gx, ch != 7'd0};
    endfunction

    task automatic host_wr(input logic [11:0] a, input logic [6:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        tick(1);
        wr_en = 1'b0;
        if (a < 12'(NCELL)) model[a] = c;
    endtask

    // Counts cycles busy stays high; the optional extra action fires at cycle 'at'.
    task automatic count_busy(input string name, input int at, input bit do_clear,
                              input bit do_wr);
        int cnt = 0;
        chk({name, "_rise"}, 32'(busy), 32'd1);
        while (busy && cnt < 5000) begin
            clear = do_clear && (cnt == at);
            wr_en = do_wr && (cnt == at);
            wr_addr = 12'd5; wr_char = 7'h41;
            tick(1);
            cnt++;
        end
        clear = 1'b0; wr_en = 1'b0;
        chk({name, "_len"}, 32'(cnt), 32'd2400);
    endtask

    task automatic scan_all(input string name);
        for (int i = 0; i < NCELL; i++) begin
            int row = i / 80;
            int col = i % 80;
            logic [2:0] gx = 3'(col % 8);
            logic [3:0] gy = 4'(row % 16);
            DrawX = 10'(col * 8) + 10'(gx);
            DrawY = 10'(row * 16) + 10'(gy);
            tick(2);
            chk(name, 32'(pix_now()), 32'(pix_exp(model[i], gy, gx)));
        end
    endtask

    initial begin
        Reset_n = 1'b0; DrawX = '0; DrawY = '0; wr_en = 1'b0;
        wr_addr = '0; wr_char = '0; clear = 1'b0;
        for (int i = 0; i < NCELL; i++) model[i] = 7'd0;

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_pix", 32'(pix_now()), 32'd0);

        // Power-up sweep; write to cell 5 at cycle 100 must be dropped
        Reset_n = 1'b1;
        tick(1);
        count_busy("pwrup", 100, 1'b0, 1'b1);

        host_wr(12'd0, 7'h41);
        host_wr(12'd161, 7'h48);
        host_wr(12'd2399, 7'h7E);
        host_wr(12'd2400, 7'h7F);

        vecs[0] = '{10'd0,    10'd0,    16'h4107 << 1 | 16'd1};
        vecs[1] = '{10'd13,   10'd37,   {11'h485, 4'd2, 1'b1}};
        vecs[2] = '{10'd640,  10'd37,   16'h0000};
        vecs[3] = '{10'd7,    10'd15,   {11'h41F, 4'd0, 1'b1}};
        vecs[4] = '{10'd8,    10'd0,    {11'h000, 4'd7, 1'b0}};
        vecs[5] = '{10'd40,   10'd0,    {11'h000, 4'd7, 1'b0}};
        vecs[6] = '{10'd15,   10'd47,   {11'h48F, 4'd0, 1'b1}};
        vecs[7] = '{10'd0,    10'd480,  16'h0000};
        vecs[8] = '{10'd639,  10'd479,  {11'h7EF, 4'd0, 1'b1}};
        vecs[9] = '{10'd1023, 10'd1023, 16'h0000};

        for (int i = 0; i < 10; i++) begin
            DrawX = vecs[i].x; DrawY = vecs[i].y;
            tick(2);
            chk($sformatf("vec%0d", i), 32'(pix_now()), 32'(vecs[i].exp));
        end

        scan_all("scan1");

        // Read-during-write on cell 3: first read sees old blank, next sees new
        DrawX = 10'd24; DrawY = 10'd0;
        tick(2);
        host_wr(12'd3, 7'h33);
        tick(0);
        @(posedge Clk); #1;
        chk("rdw_old", 32'(pix_now()), 32'({11'h000, 4'd7, 1'b0}));
        tick(1);
        chk("rdw_new", 32'(pix_now()), 32'({11'h330, 4'd7, 1'b1}));

        // Fill with 0x55, then clear with a second ignored pulse 10 cycles in
        for (int i = 0; i < 16; i++) host_wr(12'(i * 150), 7'h55);
        DrawX = 10'd0; DrawY = 10'd0;
        tick(2);
        chk("fill55", 32'(pix_now()), 32'({11'h550, 4'd7, 1'b1}));
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        count_busy("clr2", 10, 1'b1, 1'b0);
        for (int i = 0; i < NCELL; i++) model[i] = 7'd0;
        scan_all("scan_clr");

        // Reset in the middle of a sweep, with a still-visible cell on screen
        host_wr(12'd2000, 7'h41);
        DrawX = 10'd0; DrawY = 10'd400;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1000);
        chk("partial_pix", 32'(pix_now()), 32'({11'h410, 4'd7, 1'b1}));
        Reset_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_pix", 32'(pix_now()), 32'd0);
        tick(2);
        Reset_n = 1'b1;
        tick(1);
        count_busy("rst_mid", 0, 1'b0, 1'b0);
        model[2000] = 7'd0;
        tick(2);
        chk("post_rst_pix", 32'(pix_now()), 32'({11'h000, 4'd7, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
